// File: rtl/jtag_bridge_pkg.sv
//------------------------------------------------------------------------------
// jtag_bridge_pkg
//   Shared constants for the JTAG-to-memory bridge: virtual IR instruction
//   codes, the request FSM state encoding and the STATUS capture bit layout.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package jtag_bridge_pkg;

    // Virtual IR instruction codes (widened to IR_WIDTH in the top level)
    localparam int IR_CTRL   = 0;
    localparam int IR_ADDR   = 1;
    localparam int IR_WDATA  = 2;
    localparam int IR_RDATA  = 3;
    localparam int IR_STATUS = 4;

    // CTRL data register bits acted on at update
    localparam int CTRL_CPU_RESET_BIT = 0;
    localparam int CTRL_CLR_OVR_BIT   = 1;

    // STATUS capture layout
    localparam int STATUS_BUSY_BIT    = 0;
    localparam int STATUS_OVERRUN_BIT = 1;

    // Memory request FSM
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2
    } req_state_t;

endpackage

// File: rtl/jtag_input_sync.sv
//------------------------------------------------------------------------------
// jtag_input_sync
//   Brings the asynchronous virtual-JTAG signals into the system clock domain.
//   Every input goes through a 2-flop synchroniser; tck, udr and uir get a
//   third flop so their edges can be detected as single-cycle pulses.
//   The clock must be at least 4x TCK so every TCK phase is seen.
//
// Ports:
//   i_clk, i_rst        system clock, asynchronous active-high reset
//   i_tck..i_uir        raw JTAG-side inputs
//   o_tck_rise/fall     one-cycle pulses on synchronised TCK edges
//   o_udr_rise          one-cycle pulse on entry to update-DR
//   o_uir_rise          one-cycle pulse on entry to update-IR
//   o_tdi/o_ir/o_cdr/o_sdr  synchronised levels
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module jtag_input_sync #(
    parameter int IR_WIDTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_tck,
    input  logic                i_tdi,
    input  logic [IR_WIDTH-1:0] i_ir,
    input  logic                i_cdr,
    input  logic                i_sdr,
    input  logic                i_udr,
    input  logic                i_uir,
    output logic                o_tck_rise,
    output logic                o_tck_fall,
    output logic                o_udr_rise,
    output logic                o_uir_rise,
    output logic                o_tdi,
    output logic [IR_WIDTH-1:0] o_ir,
    output logic                o_cdr,
    output logic                o_sdr
);

    // Bit positions inside the packed synchroniser vector
    localparam int B_TCK = 0;
    localparam int B_TDI = 1;
    localparam int B_CDR = 2;
    localparam int B_SDR = 3;
    localparam int B_UDR = 4;
    localparam int B_UIR = 5;
    localparam int B_IR  = 6;
    localparam int SW    = IR_WIDTH + 6;

    logic [SW-1:0] w_async;
    logic [SW-1:0] r_meta;
    logic [SW-1:0] r_sync;
    logic [2:0]    r_last;   // {uir, udr, tck} delayed one more cycle

    assign w_async = {i_ir, i_uir, i_udr, i_sdr, i_cdr, i_tdi, i_tck};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_last <= '0;
        end else begin
            r_meta <= w_async;
            r_sync <= r_meta;
            r_last <= {r_sync[B_UIR], r_sync[B_UDR], r_sync[B_TCK]};
        end
    end

    assign o_tck_rise = r_sync[B_TCK]  & ~r_last[0];
    assign o_tck_fall = ~r_sync[B_TCK] &  r_last[0];
    assign o_udr_rise = r_sync[B_UDR]  & ~r_last[1];
    assign o_uir_rise = r_sync[B_UIR]  & ~r_last[2];
    assign o_tdi      = r_sync[B_TDI];
    assign o_cdr      = r_sync[B_CDR];
    assign o_sdr      = r_sync[B_SDR];
    assign o_ir       = r_sync[SW-1:B_IR];

endmodule

// File: rtl/jtag_mem_bridge.sv
//------------------------------------------------------------------------------
// jtag_mem_bridge
//   Bridges a virtual-JTAG user data register onto a single-outstanding
//   memory request port (write and read-back) and drives the CPU hold-reset
//   line. All JTAG signals are sampled in the clk domain; there is no
//   TCK-clocked logic.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   jtag_tck/tdi/ir            virtual JTAG clock, data in, instruction
//   jtag_cdr/sdr/udr/uir       virtual capture-DR/shift-DR/update-DR/update-IR
//   jtag_tdo                   registered TDO, changes on TCK falling edge
//   mem_req_valid/ready        request handshake
//   mem_req_write              1 = write, 0 = read
//   mem_addr, mem_wdata        request payload, stable while valid
//   mem_rdata_valid, mem_rdata read response
//   cpu_reset                  holds the CPU in reset while 1
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module jtag_mem_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_INCR  = 4,
    parameter int IR_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  jtag_tck,
    input  logic                  jtag_tdi,
    input  logic [IR_WIDTH-1:0]   jtag_ir,
    input  logic                  jtag_cdr,
    input  logic                  jtag_sdr,
    input  logic                  jtag_udr,
    input  logic                  jtag_uir,
    output logic                  jtag_tdo,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_reset
);

    import jtag_bridge_pkg::*;

    localparam logic [IR_WIDTH-1:0]   LP_IR_CTRL   = IR_WIDTH'(IR_CTRL);
    localparam logic [IR_WIDTH-1:0]   LP_IR_ADDR   = IR_WIDTH'(IR_ADDR);
    localparam logic [IR_WIDTH-1:0]   LP_IR_WDATA  = IR_WIDTH'(IR_WDATA);
    localparam logic [IR_WIDTH-1:0]   LP_IR_RDATA  = IR_WIDTH'(IR_RDATA);
    localparam logic [IR_WIDTH-1:0]   LP_IR_STATUS = IR_WIDTH'(IR_STATUS);
    localparam logic [ADDR_WIDTH-1:0] LP_INCR      = ADDR_WIDTH'(ADDR_INCR);

    // Synchronised JTAG side
    logic                  w_tck_rise;
    logic                  w_tck_fall;
    logic                  w_udr_rise;
    logic                  w_uir_rise;
    logic                  w_tdi_s;
    logic [IR_WIDTH-1:0]   w_ir_s;
    logic                  w_cdr_s;
    logic                  w_sdr_s;

    // TCK-side state
    logic [IR_WIDTH-1:0]   r_ir;
    logic [DATA_WIDTH-1:0] r_dr;
    logic                  r_tdo;
    logic [DATA_WIDTH-1:0] w_capture;

    // Bridge state
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_rbuf;
    logic                  r_overrun;
    logic                  r_cpu_reset;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_write;

    // Request FSM
    req_state_t            r_state;
    req_state_t            w_state_next;
    logic                  w_busy;
    logic                  w_mem_upd;
    logic                  w_issue;
    logic                  w_drop;
    logic                  w_wr_done;
    logic                  w_rd_done;

    jtag_input_sync #(
        .IR_WIDTH (IR_WIDTH)
    ) u_sync (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_tck      (jtag_tck),
        .i_tdi      (jtag_tdi),
        .i_ir       (jtag_ir),
        .i_cdr      (jtag_cdr),
        .i_sdr      (jtag_sdr),
        .i_udr      (jtag_udr),
        .i_uir      (jtag_uir),
        .o_tck_rise (w_tck_rise),
        .o_tck_fall (w_tck_fall),
        .o_udr_rise (w_udr_rise),
        .o_uir_rise (w_uir_rise),
        .o_tdi      (w_tdi_s),
        .o_ir       (w_ir_s),
        .o_cdr      (w_cdr_s),
        .o_sdr      (w_sdr_s)
    );

    assign w_busy = (r_state != ST_IDLE);

    // Value loaded into the DR on capture, selected by the registered IR
    always_comb begin
        w_capture = '0;
        case (r_ir)
            LP_IR_ADDR:   w_capture[ADDR_WIDTH-1:0] = r_addr;
            LP_IR_RDATA:  w_capture = r_rbuf;
            LP_IR_STATUS: begin
                w_capture[STATUS_BUSY_BIT]    = w_busy;
                w_capture[STATUS_OVERRUN_BIT] = r_overrun;
            end
            default: w_capture = '0;
        endcase
    end

    // Update-DR on a memory instruction; accepted only when idle
    assign w_mem_upd = w_udr_rise && ((r_ir == LP_IR_WDATA) || (r_ir == LP_IR_RDATA));
    assign w_drop    = w_mem_upd && w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_wr_done    = 1'b0;
        w_rd_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_upd) begin
                    w_issue      = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    if (r_mem_write) begin
                        w_wr_done    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (mem_rdata_valid) begin
                    w_rd_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // JTAG data path: IR latch, capture/shift of the DR, TDO on falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir  <= LP_IR_CTRL;
            r_dr  <= '0;
            r_tdo <= 1'b0;
        end else begin
            if (w_uir_rise) begin
                r_ir <= w_ir_s;
            end
            // Capture and shift are exclusive TAP states; capture wins if both appear
            if (w_tck_rise) begin
                if (w_cdr_s) begin
                    r_dr <= w_capture;
                end else if (w_sdr_s) begin
                    r_dr <= {w_tdi_s, r_dr[DATA_WIDTH-1:1]};
                end
            end
            if (w_tck_fall) begin
                r_tdo <= r_dr[0];
            end
        end
    end

    // Update handling, request payload and completion bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_rbuf      <= '0;
            r_overrun   <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_write <= 1'b0;
        end else begin
            if (w_wr_done || w_rd_done) begin
                r_addr <= r_addr + LP_INCR;
            end
            if (w_rd_done) begin
                r_rbuf <= mem_rdata;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            // Payload is frozen here so later ADDR updates do not disturb it
            if (w_issue) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= r_dr;
                r_mem_write <= (r_ir == LP_IR_WDATA);
            end
            // CTRL/ADDR updates apply even while busy; an explicit ADDR write
            // takes priority over a completion increment in the same cycle
            if (w_udr_rise) begin
                case (r_ir)
                    LP_IR_CTRL: begin
                        r_cpu_reset <= r_dr[CTRL_CPU_RESET_BIT];
                        if (r_dr[CTRL_CLR_OVR_BIT]) begin
                            r_overrun <= 1'b0;
                        end
                    end
                    LP_IR_ADDR: r_addr <= r_dr[ADDR_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign jtag_tdo      = r_tdo;
    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_req_write = r_mem_write;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign cpu_reset     = r_cpu_reset;

endmodule

// File: tb/tb_jtag_mem_bridge.sv
`timescale 1ns/1ps
module tb_jtag_mem_bridge;

    localparam logic [3:0] IR_CTRL   = 4'd0;
    localparam logic [3:0] IR_ADDR   = 4'd1;
    localparam logic [3:0] IR_WDATA  = 4'd2;
    localparam logic [3:0] IR_RDATA  = 4'd3;
    localparam logic [3:0] IR_STATUS = 4'd4;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jtag_tck = 1'b0;
    logic        jtag_tdi = 1'b0;
    logic [3:0]  jtag_ir = 4'd0;
    logic        jtag_cdr = 1'b0;
    logic        jtag_sdr = 1'b0;
    logic        jtag_udr = 1'b0;
    logic        jtag_uir = 1'b0;
    logic        jtag_tdo;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        cpu_reset;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    int          stall = 0;
    int          rd_lat = 3;
    bit          mem_hold = 1'b0;

    req_t        exp_req_q [$];
    string       cap_name_q [$];
    logic [31:0] cap_exp_q [$];
    logic [31:0] obs_q [$];
    event        scan_done;
    logic        upd_cpu_reset = 1'b0;

    always #5 clk = ~clk;

    jtag_mem_bridge #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .ADDR_INCR  (4),
        .IR_WIDTH   (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .jtag_tck        (jtag_tck),
        .jtag_tdi        (jtag_tdi),
        .jtag_ir         (jtag_ir),
        .jtag_cdr        (jtag_cdr),
        .jtag_sdr        (jtag_sdr),
        .jtag_udr        (jtag_udr),
        .jtag_uir        (jtag_uir),
        .jtag_tdo        (jtag_tdo),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_write   (mem_req_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .cpu_reset       (cpu_reset)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tck_cycle();
        #10 jtag_tck = 1'b1;
        #50 jtag_tck = 1'b0;
        #40;
    endtask

    task automatic set_ir(input logic [3:0] code);
        jtag_ir = code;
        #10 jtag_uir = 1'b1;
        #40 jtag_uir = 1'b0;
        #20;
    endtask

    task automatic pulse_udr();
        jtag_udr = 1'b1;
        #40 jtag_udr = 1'b0;
        #20;
    endtask

    // Full capture / shift / update sequence; the captured word is handed to
    // the capture monitor, the expected word is queued beforehand.
    task automatic scan(input string nm, input logic [31:0] din, input logic [31:0] cap_exp);
        logic [31:0] dout;
        cap_name_q.push_back(nm);
        cap_exp_q.push_back(cap_exp);
        jtag_cdr = 1'b1;
        tck_cycle();
        jtag_cdr = 1'b0;
        jtag_sdr = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dout[i]  = jtag_tdo;
            jtag_tdi = din[i];
            tck_cycle();
        end
        jtag_sdr = 1'b0;
        jtag_tdi = 1'b0;
        obs_q.push_back(dout);
        ->scan_done;
        jtag_udr = 1'b1;
        repeat (6) @(posedge clk);
        #1 upd_cpu_reset = cpu_reset;
        @(negedge clk);
        jtag_tck = 1'b1;
        #50 jtag_tck = 1'b0;
        #20 jtag_udr = 1'b0;
        #30;
    endtask

    // Capture monitor
    initial begin
        string       nm;
        logic [31:0] o;
        logic [31:0] e;
        forever begin
            @(scan_done);
            while (obs_q.size() > 0 && cap_exp_q.size() > 0) begin
                o  = obs_q.pop_front();
                e  = cap_exp_q.pop_front();
                nm = cap_name_q.pop_front();
                check(nm, o, e);
            end
        end
    end

    // Request monitor: every accepted request must match the queue head
    req_t mon_r;
    always @(negedge clk) begin
        if (!reset && mem_req_valid && mem_req_ready) begin
            if (exp_req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req: got addr 0x%08h write %0d, expected no request", mem_addr, mem_req_write);
            end else begin
                mon_r = exp_req_q.pop_front();
                check("req_write", 32'(mem_req_write), 32'(mon_r.wr));
                check("req_addr", mem_addr, mon_r.addr);
                if (mon_r.wr) check("req_wdata", mem_wdata, mon_r.data);
            end
        end
    end

    // Memory responder
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req_valid && !mem_hold && !reset) begin
                for (int k = 0; k < stall; k++) begin
                    if (exp_req_q.size() > 0) begin
                        check("stall_addr", mem_addr, exp_req_q[0].addr);
                        if (exp_req_q[0].wr) check("stall_wdata", mem_wdata, exp_req_q[0].data);
                    end
                    @(posedge clk);
                    #1;
                end
                a = mem_addr;
                d = mem_wdata;
                w = mem_req_write;
                mem_req_ready = 1'b1;
                @(posedge clk);
                #1 mem_req_ready = 1'b0;
                if (w) begin
                    mem[a] = d;
                end else begin
                    repeat (rd_lat - 1) @(posedge clk);
                    #1;
                    mem_rdata_valid = 1'b1;
                    mem_rdata = mem.exists(a) ? mem[a] : 32'h0;
                    @(posedge clk);
                    #1 mem_rdata_valid = 1'b0;
                    mem_rdata = 32'h0;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at 1ms, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        #25;
        check("rst_cpu_reset", 32'(cpu_reset), 32'h0);
        check("rst_valid", 32'(mem_req_valid), 32'h0);
        check("rst_tdo", 32'(jtag_tdo), 32'h0);
        check("rst_write", 32'(mem_req_write), 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        #15 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        set_ir(IR_STATUS);
        scan("status_reset", 32'h0, 32'h0);

        // CTRL: cpu_reset on and off
        set_ir(IR_CTRL);
        scan("ctrl_cap_a", 32'h1, 32'h0);
        check("cpu_reset_set", 32'(upd_cpu_reset), 32'h1);
        scan("ctrl_cap_b", 32'h0, 32'h0);
        check("cpu_reset_clr", 32'(upd_cpu_reset), 32'h0);

        // Two stalled writes, address auto-increment
        stall = 5;
        set_ir(IR_ADDR);
        scan("addr_cap_init", 32'h0000_1000, 32'h0);
        set_ir(IR_WDATA);
        exp_req_q.push_back('{1'b1, 32'h0000_1000, 32'hDEAD_BEEF});
        scan("wdata_cap_a", 32'hDEAD_BEEF, 32'h0);
        exp_req_q.push_back('{1'b1, 32'h0000_1004, 32'hCAFE_F00D});
        scan("wdata_cap_b", 32'hCAFE_F00D, 32'h0);
        set_ir(IR_ADDR);
        scan("addr_after_wr", 32'h0000_1000, 32'h0000_1008);
        stall = 0;

        // Prefetching reads
        mem[32'h0000_1000] = 32'h1111_1111;
        mem[32'h0000_1004] = 32'h2222_2222;
        set_ir(IR_RDATA);
        exp_req_q.push_back('{1'b0, 32'h0000_1000, 32'h0});
        scan("rdata_scan1", 32'h0, 32'h0);
        exp_req_q.push_back('{1'b0, 32'h0000_1004, 32'h0});
        scan("rdata_scan2", 32'h0, 32'h1111_1111);
        exp_req_q.push_back('{1'b0, 32'h0000_1008, 32'h0});
        scan("rdata_scan3", 32'h0, 32'h2222_2222);
        set_ir(IR_ADDR);
        scan("addr_after_rd", 32'h0000_100C, 32'h0000_100C);

        // Overrun during a slow read
        rd_lat = 40;
        set_ir(IR_RDATA);
        exp_req_q.push_back('{1'b0, 32'h0000_100C, 32'h0});
        pulse_udr();
        set_ir(IR_WDATA);
        pulse_udr();
        set_ir(IR_STATUS);
        scan("status_busy_ovr", 32'h0, 32'h3);
        scan("status_idle_ovr", 32'h0, 32'h2);
        rd_lat = 3;
        set_ir(IR_CTRL);
        scan("ctrl_clr_cap", 32'h2, 32'h0);
        set_ir(IR_STATUS);
        scan("status_cleared", 32'h0, 32'h0);

        // Address wrap
        set_ir(IR_ADDR);
        scan("addr_pre_wrap", 32'hFFFF_FFFC, 32'h0000_1010);
        set_ir(IR_WDATA);
        exp_req_q.push_back('{1'b1, 32'hFFFF_FFFC, 32'h1234_5678});
        scan("wdata_wrap", 32'h1234_5678, 32'h0);
        set_ir(IR_ADDR);
        scan("addr_wrapped", 32'h0000_2000, 32'h0);

        // Reset while a request is pending
        set_ir(IR_CTRL);
        scan("ctrl_hold_cap", 32'h1, 32'h0);
        check("cpu_reset_hold", 32'(upd_cpu_reset), 32'h1);
        mem_hold = 1'b1;
        set_ir(IR_WDATA);
        scan("wdata_abandon", 32'h5A5A_5A5A, 32'h0);
        check("pend_valid", 32'(mem_req_valid), 32'h1);
        check("pend_addr", mem_addr, 32'h0000_2000);
        check("pend_wdata", mem_wdata, 32'h5A5A_5A5A);
        @(posedge clk);
        #2 reset = 1'b1;
        #2;
        check("async_rst_valid", 32'(mem_req_valid), 32'h0);
        check("async_rst_cpu", 32'(cpu_reset), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_valid", 32'(mem_req_valid), 32'h0);
        set_ir(IR_ADDR);
        scan("addr_post_rst", 32'h0000_3000, 32'h0);
        set_ir(IR_WDATA);
        exp_req_q.push_back('{1'b1, 32'h0000_3000, 32'hA5A5_A5A5});
        scan("wdata_post_rst", 32'hA5A5_A5A5, 32'h0);
        set_ir(IR_ADDR);
        scan("addr_after_post", 32'h0000_3000, 32'h0000_3004);

        repeat (20) @(negedge clk);
        check("req_queue_empty", 32'(exp_req_q.size()), 32'h0);
        check("cap_queue_empty", 32'(cap_exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
